// File: rtl/frg_pkg.sv
// Shared types and helpers for the frame credit / tready generator.
package frg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FULL
    } frg_state_e;

    function automatic int unsigned frg_cnt_w(input int unsigned max_out);
        return (max_out < 1) ? 1 : $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/frg_watchdog.sv
// Idle watchdog: pulses fire after WDOG_CYCLES consecutive active cycles without a kick.
module frg_watchdog #(
    parameter int unsigned WDOG_CYCLES = 4096
) (
    input  logic clk,
    input  logic nrst,
    input  logic active,
    input  logic kick,
    output logic fire
);

    localparam int unsigned W = (WDOG_CYCLES < 2) ? 1 : $clog2(WDOG_CYCLES);
    localparam logic [W-1:0] LAST = W'(WDOG_CYCLES - 1);
    localparam logic [W-1:0] ONE  = W'(1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        fire  = active & ~kick & (cnt_q == LAST);
        cnt_d = cnt_q + ONE;
        if (!active || kick || fire) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/frame_credit_ready.sv
// AXI-Stream tready generator limiting accepted-but-unfinished frames to MAX_OUTSTANDING.
// Optional hung-core recovery watchdog enabled by defining FRG_WATCHDOG_EN.
module frame_credit_ready
    import frg_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 1,
    parameter int unsigned BEAT_W          = 16,
    parameter int unsigned WDOG_CYCLES     = 4096,
    localparam int unsigned CNT_W          = frg_cnt_w(MAX_OUTSTANDING)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              tvalid,
    input  logic              tlast,
    input  logic              finish,
    input  logic              clr_err,
    output logic              ready,
    output logic [CNT_W-1:0]  outstanding,
    output logic [BEAT_W-1:0] beat_count,
    output logic              len_valid,
    output logic [BEAT_W-1:0] frame_len,
    output logic              err_underflow,
    output logic              wdog_fired
);

    localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [BEAT_W-1:0] BEAT_ONE = BEAT_W'(1);

    if (MAX_OUTSTANDING < 1 || WDOG_CYCLES < 1) begin : g_bad_cfg
        $error("frame_credit_ready: MAX_OUTSTANDING and WDOG_CYCLES must be >= 1");
    end

    frg_state_e        state_q, state_d;
    logic              ready_q, ready_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [BEAT_W-1:0] beat_count_q, beat_count_d;
    logic              len_valid_q, len_valid_d;
    logic [BEAT_W-1:0] frame_len_q, frame_len_d;
    logic              err_q, err_d;

    logic              acc;
    logic              frame_end;
    logic              underflow;
    logic              dec;
    logic              wdog_fire;
    logic [BEAT_W-1:0] beat_inc;

    always_comb begin
        acc       = tvalid & ready_q;
        frame_end = acc & tlast;
        underflow = finish & (outstanding_q == '0);
        dec       = finish & ~underflow;
        beat_inc  = (beat_count_q == '1) ? beat_count_q : beat_count_q + BEAT_ONE;

        outstanding_d = outstanding_q;
        if (frame_end && !dec) begin
            outstanding_d = outstanding_q + CNT_ONE;
        end else if (dec && !frame_end) begin
            outstanding_d = outstanding_q - CNT_ONE;
        end
        if (wdog_fire) begin
            outstanding_d = '0;
        end

        // FSM tracks the next credit count so ready is registered with one-cycle latency
        if (outstanding_d == '0) begin
            state_d = IDLE;
        end else if (outstanding_d == MAX_CNT) begin
            state_d = FULL;
        end else begin
            state_d = BUSY;
        end
        ready_d = (state_d != FULL);

        beat_count_d = beat_count_q;
        frame_len_d  = frame_len_q;
        len_valid_d  = 1'b0;
        if (frame_end) begin
            beat_count_d = '0;
            frame_len_d  = beat_inc;
            len_valid_d  = 1'b1;
        end else if (acc) begin
            beat_count_d = beat_inc;
        end

        err_d = (err_q & ~clr_err) | underflow;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q       <= IDLE;
            ready_q       <= 1'b1;
            outstanding_q <= '0;
            beat_count_q  <= '0;
            len_valid_q   <= 1'b0;
            frame_len_q   <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            ready_q       <= ready_d;
            outstanding_q <= outstanding_d;
            beat_count_q  <= beat_count_d;
            len_valid_q   <= len_valid_d;
            frame_len_q   <= frame_len_d;
            err_q         <= err_d;
        end
    end

`ifdef FRG_WATCHDOG_EN
    logic wdog_q, wdog_d;

    frg_watchdog #(
        .WDOG_CYCLES(WDOG_CYCLES)
    ) u_wdog (
        .clk    (clk),
        .nrst   (nrst),
        .active (outstanding_q != '0),
        .kick   (finish | frame_end),
        .fire   (wdog_fire)
    );

    always_comb begin
        wdog_d = (wdog_q & ~clr_err) | wdog_fire;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wdog_q <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
        end
    end

    assign wdog_fired = wdog_q;
`else
    assign wdog_fire  = 1'b0;
    assign wdog_fired = 1'b0;
`endif

    assign ready         = ready_q;
    assign outstanding   = outstanding_q;
    assign beat_count    = beat_count_q;
    assign len_valid     = len_valid_q;
    assign frame_len     = frame_len_q;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_frame_credit_ready.sv
// Self-checking bench: three instances (MAX_OUTSTANDING 1/2/3) share stimulus, checked against a credit model.
module tb_frame_credit_ready;

    localparam int BW   = 4;
    localparam int WD   = 16;
    localparam int BMAX = (1 << BW) - 1;

    logic clk = 1'b0;
    logic nrst;
    logic tvalid, tlast, finish, clr_err;

    logic          r1, r2, r3;
    logic [0:0]    o1;
    logic [1:0]    o2, o3;
    logic [BW-1:0] b1, b2, b3, f1, f2, f3;
    logic          lv1, lv2, lv3, e1, e2, e3, w1, w2, w3;

    frame_credit_ready #(.MAX_OUTSTANDING(1), .BEAT_W(BW), .WDOG_CYCLES(WD)) u_dut1 (
        .clk(clk), .nrst(nrst), .tvalid(tvalid), .tlast(tlast), .finish(finish), .clr_err(clr_err),
        .ready(r1), .outstanding(o1), .beat_count(b1), .len_valid(lv1), .frame_len(f1),
        .err_underflow(e1), .wdog_fired(w1));

    frame_credit_ready #(.MAX_OUTSTANDING(2), .BEAT_W(BW), .WDOG_CYCLES(WD)) u_dut2 (
        .clk(clk), .nrst(nrst), .tvalid(tvalid), .tlast(tlast), .finish(finish), .clr_err(clr_err),
        .ready(r2), .outstanding(o2), .beat_count(b2), .len_valid(lv2), .frame_len(f2),
        .err_underflow(e2), .wdog_fired(w2));

    frame_credit_ready #(.MAX_OUTSTANDING(3), .BEAT_W(BW), .WDOG_CYCLES(WD)) u_dut3 (
        .clk(clk), .nrst(nrst), .tvalid(tvalid), .tlast(tlast), .finish(finish), .clr_err(clr_err),
        .ready(r3), .outstanding(o3), .beat_count(b3), .len_valid(lv3), .frame_len(f3),
        .err_underflow(e3), .wdog_fired(w3));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: frames in flight, beats so far, sticky flags, cycles since last event
    int m_out[3], m_beat[3], m_flen[3], m_lenv[3], m_err[3], m_wd[3], m_idle[3], m_rdy[3];

    typedef struct {
        bit tv, tl, fin, clr;
        int e_rdy, e_out, e_beat, e_lenv, e_flen, e_err;
    } vec_t;

    vec_t vec[11];

    task automatic chk(input string name, input integer act, input integer exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_out[i] = 0; m_beat[i] = 0; m_flen[i] = 0; m_lenv[i] = 0;
            m_err[i] = 0; m_wd[i] = 0; m_idle[i] = 0; m_rdy[i] = 1;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            int mx, n;
            bit acc, fe, dec, uf, fire;
            mx   = i + 1;
            acc  = tvalid && (m_rdy[i] != 0);
            fe   = acc && tlast;
            dec  = finish && (m_out[i] > 0);
            uf   = finish && (m_out[i] == 0);
            fire = 1'b0;
`ifdef FRG_WATCHDOG_EN
            if (m_out[i] > 0 && !finish && !fe) begin
                m_idle[i]++;
                if (m_idle[i] == WD) begin
                    fire = 1'b1;
                    m_idle[i] = 0;
                end
            end else begin
                m_idle[i] = 0;
            end
`endif
            n = m_out[i] + (fe ? 1 : 0) - (dec ? 1 : 0);
            if (fire) n = 0;
            m_out[i] = n;
            m_rdy[i] = (n < mx) ? 1 : 0;
            m_lenv[i] = 0;
            if (fe) begin
                m_flen[i] = (m_beat[i] + 1 > BMAX) ? BMAX : m_beat[i] + 1;
                m_beat[i] = 0;
                m_lenv[i] = 1;
            end else if (acc) begin
                m_beat[i] = (m_beat[i] + 1 > BMAX) ? BMAX : m_beat[i] + 1;
            end
            m_err[i] = ((m_err[i] != 0 && !clr_err) || uf) ? 1 : 0;
            m_wd[i]  = ((m_wd[i] != 0 && !clr_err) || fire) ? 1 : 0;
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 3; i++) begin
            integer rd, ou, be, lv, fl, er, wf;
            case (i)
                0: begin rd = r1; ou = o1; be = b1; lv = lv1; fl = f1; er = e1; wf = w1; end
                1: begin rd = r2; ou = o2; be = b2; lv = lv2; fl = f2; er = e2; wf = w2; end
                default: begin rd = r3; ou = o3; be = b3; lv = lv3; fl = f3; er = e3; wf = w3; end
            endcase
            chk($sformatf("%s.m%0d.ready", tag, i + 1), rd, m_rdy[i]);
            chk($sformatf("%s.m%0d.outstanding", tag, i + 1), ou, m_out[i]);
            chk($sformatf("%s.m%0d.beat_count", tag, i + 1), be, m_beat[i]);
            chk($sformatf("%s.m%0d.len_valid", tag, i + 1), lv, m_lenv[i]);
            chk($sformatf("%s.m%0d.frame_len", tag, i + 1), fl, m_flen[i]);
            chk($sformatf("%s.m%0d.err_underflow", tag, i + 1), er, m_err[i]);
            chk($sformatf("%s.m%0d.wdog_fired", tag, i + 1), wf, m_wd[i]);
        end
    endtask

    // Called at a negedge; returns at the next negedge with outputs checked in between
    task automatic cycle(input bit v, input bit l, input bit f, input bit c, input string tag);
        tvalid = v; tlast = l; finish = f; clr_err = c;
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        tvalid = 0; tlast = 0; finish = 0; clr_err = 0;
        nrst = 1'b0;
        #1;
        model_reset();
        chk({tag, ".async_ready"}, r3, 1);
        chk({tag, ".async_outstanding"}, o3, 0);
        chk({tag, ".async_beat"}, b3, 0);
        check_all(tag);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        tvalid = 0; tlast = 0; finish = 0; clr_err = 0; nrst = 1'b0;
        //          tv tl fi cl  rdy out beat lenv flen err   (MAX=1 instance)
        vec[0]  = '{1, 0, 0, 0,  1,  0,  1,   0,   0,   0};
        vec[1]  = '{1, 0, 0, 0,  1,  0,  2,   0,   0,   0};
        vec[2]  = '{1, 0, 0, 0,  1,  0,  3,   0,   0,   0};
        vec[3]  = '{1, 1, 0, 0,  0,  1,  0,   1,   4,   0};
        vec[4]  = '{1, 1, 0, 0,  0,  1,  0,   0,   4,   0};
        vec[5]  = '{0, 0, 1, 0,  1,  0,  0,   0,   4,   0};
        vec[6]  = '{0, 0, 1, 0,  1,  0,  0,   0,   4,   1};
        vec[7]  = '{0, 0, 0, 0,  1,  0,  0,   0,   4,   1};
        vec[8]  = '{0, 0, 0, 1,  1,  0,  0,   0,   4,   0};
        vec[9]  = '{0, 0, 1, 1,  1,  0,  0,   0,   4,   1};
        vec[10] = '{0, 0, 0, 1,  1,  0,  0,   0,   4,   0};

        @(negedge clk);
        do_reset("reset");

        for (int k = 0; k < 11; k++) begin
            tvalid = vec[k].tv; tlast = vec[k].tl; finish = vec[k].fin; clr_err = vec[k].clr;
            @(posedge clk);
            model_step();
            #1;
            chk($sformatf("vec%0d.ready", k), r1, vec[k].e_rdy);
            chk($sformatf("vec%0d.outstanding", k), o1, vec[k].e_out);
            chk($sformatf("vec%0d.beat_count", k), b1, vec[k].e_beat);
            chk($sformatf("vec%0d.len_valid", k), lv1, vec[k].e_lenv);
            chk($sformatf("vec%0d.frame_len", k), f1, vec[k].e_flen);
            chk($sformatf("vec%0d.err_underflow", k), e1, vec[k].e_err);
            check_all($sformatf("vec%0d", k));
            @(negedge clk);
        end

        // Three 2-beat frames into the MAX=3 instance, then one finish
        do_reset("rst_t2");
        for (int fr = 1; fr <= 3; fr++) begin
            cycle(1, 0, 0, 0, "t2");
            cycle(1, 1, 0, 0, "t2");
            chk($sformatf("t2.frame%0d.outstanding", fr), o3, fr);
            chk($sformatf("t2.frame%0d.ready", fr), r3, (fr < 3) ? 1 : 0);
        end
        cycle(0, 0, 1, 0, "t2");
        chk("t2.finish.outstanding", o3, 2);
        chk("t2.finish.ready", r3, 1);

        // MAX=2 with one frame in flight: frame_end and finish together
        do_reset("rst_t3");
        cycle(1, 1, 0, 0, "t3");
        chk("t3.first.outstanding", o2, 1);
        cycle(1, 1, 1, 0, "t3");
        chk("t3.same.outstanding", o2, 1);
        chk("t3.same.ready", r2, 1);

        // Beat counter and frame length saturate at all-ones
        do_reset("rst_sat");
        for (int k = 0; k < 20; k++) cycle(1, 0, 0, 0, "sat");
        chk("sat.beat_count", b1, BMAX);
        cycle(1, 1, 0, 0, "sat");
        chk("sat.frame_len", f1, BMAX);
        chk("sat.len_valid", lv1, 1);

        // Reset in the middle of a frame with frames outstanding
        cycle(1, 0, 0, 0, "mid");
        cycle(1, 0, 0, 0, "mid");
        do_reset("rst_mid");

        // Stalled core: no finish after a frame is accepted
        cycle(1, 1, 0, 0, "wd");
        for (int k = 0; k < WD - 1; k++) cycle(0, 0, 0, 0, "wd");
        chk("wd.before.wdog_fired", w1, 0);
        chk("wd.before.outstanding", o1, 1);
        cycle(0, 0, 0, 0, "wd");
`ifdef FRG_WATCHDOG_EN
        chk("wd.fire.wdog_fired", w1, 1);
        chk("wd.fire.outstanding", o1, 0);
        chk("wd.fire.ready", r1, 1);
        cycle(0, 0, 0, 1, "wd");
        chk("wd.clr.wdog_fired", w1, 0);
`else
        chk("wd.hold.wdog_fired", w1, 0);
        chk("wd.hold.outstanding", o1, 1);
        chk("wd.hold.ready", r1, 0);
`endif

        // Randomized traffic with varying frame length and finish rate
        do_reset("rst_rnd");
        for (int blk = 0; blk < 8; blk++) begin
            int p_last, p_fin;
            p_last = (blk % 2 == 1) ? 3 : 30;
            p_fin  = (blk % 4 == 3) ? 2 : 15;
            for (int k = 0; k < 250; k++) begin
                cycle(($urandom_range(99) < 70), ($urandom_range(99) < p_last),
                      ($urandom_range(99) < p_fin), ($urandom_range(99) < 5), "rnd");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
